// File: rtl/dkong_pal_pkg.sv
// Shared types and constants for the palette PROM loader.
package dkong_pal_pkg;
   typedef enum logic [2:0] {IDLE, ARMED, SETUP, WRITE, DONE} pal_state_e;

   localparam int PAL_BYTES  = 512;
   localparam int FIFO_DEPTH = 4;
   localparam int WAIT_LEVEL = 3;
   localparam int ENTRY_W    = 17;

   typedef struct packed {
      logic [8:0] off;
      logic [7:0] data;
   } pal_entry_t;
endpackage

// File: rtl/dkong_pal_loader_if.sv
// Download-stream handshake between the ROM download source and the palette loader.
interface dkong_pal_loader_if;
   logic        I_DL_ACTIVE;
   logic        I_DL_WR;
   logic [15:0] I_DL_ADDR;
   logic [7:0]  I_DL_DATA;
   logic        O_DL_WAIT;

   modport master (output I_DL_ACTIVE, I_DL_WR, I_DL_ADDR, I_DL_DATA, input O_DL_WAIT);
   modport slave  (input I_DL_ACTIVE, I_DL_WR, I_DL_ADDR, I_DL_DATA, output O_DL_WAIT);
endinterface

// File: rtl/dkong_pal_fifo.sv
// 4-entry register FIFO holding {offset, data} palette bytes awaiting their RAM write.
module dkong_pal_fifo
   import dkong_pal_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic       CLK_6M,
   input  logic       W_1EF_RST,
   input  logic       push,
   input  pal_entry_t din,
   input  logic       pop,
   output pal_entry_t dout,
   output logic [2:0] count,
   output logic       full,
   output logic       empty
);
   pal_entry_t mem_q [4];
   pal_entry_t mem_d [4];
   logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [2:0] count_q, count_d;
   logic       push_ok, pop_ok;

   assign full    = (count_q == 3'(DEPTH));
   assign empty   = (count_q == 3'd0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
   assign push_ok = push & (~full | pop);
   assign pop_ok  = pop & ~empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + 2'd1;
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + 2'd1;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK_6M or negedge W_1EF_RST) begin
      if (!W_1EF_RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge CLK_6M) begin
      mem_q <= mem_d;
   end
endmodule

// File: rtl/dkong_pal_loader.sv
// Palette PROM loader: buffers download bytes and writes them into palette banks 2E/2F.
// Optional running checksum on O_CHKSUM is built only when DKONG_PAL_CHKSUM_EN is defined.
module dkong_pal_loader #(
   parameter logic [15:0] BASE_ADDR  = 16'h0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic              CLK_6M,
   input  logic              W_1EF_RST,
   dkong_pal_loader_if.slave dl,
   output logic              O_CNF_EN,
   output logic [7:0]        O_CNF_A,
   output logic [7:0]        O_CNF_D,
   output logic              O_WE2,
   output logic              O_WE3,
   output logic              O_DONE,
   output logic [9:0]        O_COUNT,
   output logic              O_OVF,
   output logic [15:0]       O_CHKSUM
);
   import dkong_pal_pkg::*;

   pal_state_e state_q, state_d;
   logic       act_prev_q, cnf_en_q, cnf_en_d, bank_q, bank_d;
   logic [7:0] cnf_a_q, cnf_a_d, cnf_d_q, cnf_d_d;
   logic       we2_q, we2_d, we3_q, we3_d, done_q, done_d;
   logic [9:0] count_q, count_d;
   logic       ovf_q, ovf_d, wait_q;

   logic [16:0] dl_off;
   logic        win_hit, push, pop, drop, act_rise;
   pal_entry_t  push_ent, pop_ent;
   logic [2:0]  fifo_count;
   logic        fifo_full, fifo_empty;

   // 17-bit difference: bit 16 flags addresses below the window, bits 15:9 those above it.
   assign dl_off   = {1'b0, dl.I_DL_ADDR} - {1'b0, BASE_ADDR};
   assign win_hit  = (dl_off[16:9] == 8'd0);
   assign push     = dl.I_DL_ACTIVE & dl.I_DL_WR & win_hit;
   assign push_ent = '{off: dl_off[8:0], data: dl.I_DL_DATA};
   assign pop      = (state_q == ARMED) & ~fifo_empty;
   assign drop     = push & fifo_full & ~pop;
   assign act_rise = dl.I_DL_ACTIVE & ~act_prev_q;

   dkong_pal_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .CLK_6M    (CLK_6M),
      .W_1EF_RST (W_1EF_RST),
      .push      (push),
      .din       (push_ent),
      .pop       (pop),
      .dout      (pop_ent),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      state_d  = state_q;
      cnf_en_d = cnf_en_q;
      cnf_a_d  = cnf_a_q;
      cnf_d_d  = cnf_d_q;
      bank_d   = bank_q;
      we2_d    = 1'b0;
      we3_d    = 1'b0;
      done_d   = 1'b0;
      count_d  = count_q;
      ovf_d    = ovf_q;
      case (state_q)
         IDLE: if (act_rise) begin
            count_d  = '0;
            ovf_d    = 1'b0;
            cnf_en_d = 1'b1;
            state_d  = ARMED;
         end
         ARMED: if (!fifo_empty) begin
            cnf_a_d = pop_ent.off[7:0];
            cnf_d_d = pop_ent.data;
            bank_d  = pop_ent.off[8];
            state_d = SETUP;
         end else if (!dl.I_DL_ACTIVE) begin
            cnf_en_d = 1'b0;
            cnf_a_d  = '0;
            cnf_d_d  = '0;
            done_d   = 1'b1;
            state_d  = DONE;
         end
         SETUP: begin
            we2_d   = ~bank_q;
            we3_d   = bank_q;
            state_d = WRITE;
         end
         WRITE: begin
            if (count_q != 10'(PAL_BYTES)) count_d = count_q + 10'd1;
            state_d = ARMED;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (drop) ovf_d = 1'b1;
   end

   always_ff @(posedge CLK_6M or negedge W_1EF_RST) begin
      if (!W_1EF_RST) begin
         state_q    <= IDLE;
         act_prev_q <= 1'b0;
         cnf_en_q   <= 1'b0;
         cnf_a_q    <= '0;
         cnf_d_q    <= '0;
         bank_q     <= 1'b0;
         we2_q      <= 1'b0;
         we3_q      <= 1'b0;
         done_q     <= 1'b0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         wait_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         act_prev_q <= dl.I_DL_ACTIVE;
         cnf_en_q   <= cnf_en_d;
         cnf_a_q    <= cnf_a_d;
         cnf_d_q    <= cnf_d_d;
         bank_q     <= bank_d;
         we2_q      <= we2_d;
         we3_q      <= we3_d;
         done_q     <= done_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         wait_q     <= (fifo_count >= 3'(WAIT_LEVEL));
      end
   end

`ifdef DKONG_PAL_CHKSUM_EN
   logic [15:0] chksum_q, chksum_d;

   always_comb begin
      chksum_d = chksum_q;
      if (state_q == IDLE && act_rise) chksum_d = '0;
      else if (state_q == WRITE)       chksum_d = chksum_q + {8'h00, cnf_d_q};
   end

   always_ff @(posedge CLK_6M or negedge W_1EF_RST) begin
      if (!W_1EF_RST) chksum_q <= '0;
      else            chksum_q <= chksum_d;
   end

   assign O_CHKSUM = chksum_q;
`else
   assign O_CHKSUM = 16'h0000;
`endif

   assign dl.O_DL_WAIT = wait_q;
   assign O_CNF_EN     = cnf_en_q;
   assign O_CNF_A      = cnf_a_q;
   assign O_CNF_D      = cnf_d_q;
   assign O_WE2        = we2_q;
   assign O_WE3        = we3_q;
   assign O_DONE       = done_q;
   assign O_COUNT      = count_q;
   assign O_OVF        = ovf_q;
endmodule

// File: tb/tb_dkong_pal_loader.sv
// Directed bench for dkong_pal_loader: hand-computed vectors plus a write-order scoreboard.
module tb_dkong_pal_loader;
   localparam logic [15:0] BASE = 16'h4000;
`ifdef DKONG_PAL_CHKSUM_EN
   localparam bit CK_EN = 1'b1;
`else
   localparam bit CK_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   dkong_pal_loader_if dl ();

   logic        o_cnf_en, o_we2, o_we3, o_done, o_ovf;
   logic [7:0]  o_cnf_a, o_cnf_d;
   logic [9:0]  o_count;
   logic [15:0] o_chksum;

   dkong_pal_loader #(.BASE_ADDR(BASE), .FIFO_DEPTH(4)) dut (
      .CLK_6M    (clk),
      .W_1EF_RST (rst_n),
      .dl        (dl),
      .O_CNF_EN  (o_cnf_en),
      .O_CNF_A   (o_cnf_a),
      .O_CNF_D   (o_cnf_d),
      .O_WE2     (o_we2),
      .O_WE3     (o_we3),
      .O_DONE    (o_done),
      .O_COUNT   (o_count),
      .O_OVF     (o_ovf),
      .O_CHKSUM  (o_chksum)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int we2_n = 0, we3_n = 0, done_n = 0;
   bit wait_seen = 1'b0;
   logic [16:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Every WE pulse must match the next expected {offset, data}, in order.
   always @(negedge clk) begin
      if (dl.O_DL_WAIT === 1'b1) wait_seen = 1'b1;
      if (o_done === 1'b1) done_n++;
      if (o_we2 === 1'b1 || o_we3 === 1'b1) begin
         if (o_we2 === 1'b1) we2_n++;
         if (o_we3 === 1'b1) we3_n++;
         chk("we_exclusive", 32'(o_we2 & o_we3), 32'd0);
         n_cmp++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL we_unexpected: observed bank=%0d a=%0h d=%0h expected no write",
                   o_we3, o_cnf_a, o_cnf_d);
         end
         if (exp_q.size() != 0)
            chk("we_write", 32'({o_we3, o_cnf_a, o_cnf_d}), 32'(exp_q.pop_front()));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [15:0] addr, input logic [7:0] data);
      dl.I_DL_WR   = 1'b1;
      dl.I_DL_ADDR = addr;
      dl.I_DL_DATA = data;
      tick();
      dl.I_DL_WR   = 1'b0;
   endtask

   task automatic expect_wr(input logic [8:0] off, input logic [7:0] data);
      exp_q.push_back({off, data});
   endtask

   task automatic start_session();
      dl.I_DL_ACTIVE = 1'b1;
      tick();
      done_n    = 0;
      wait_seen = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int n);
      n = 0;
      while (o_done !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
      chk("done_seen", 32'(o_done), 32'd1);
   endtask

   initial begin
      int n;
      logic [15:0] exp_sum;
      logic [7:0]  d;
      dl.I_DL_ACTIVE = 1'b0;
      dl.I_DL_WR     = 1'b0;
      dl.I_DL_ADDR   = '0;
      dl.I_DL_DATA   = '0;
      exp_sum        = '0;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_cnf_en", 32'(o_cnf_en), 32'd0);
      chk("rst_cnf_a",  32'(o_cnf_a),  32'd0);
      chk("rst_cnf_d",  32'(o_cnf_d),  32'd0);
      chk("rst_we2",    32'(o_we2),    32'd0);
      chk("rst_we3",    32'(o_we3),    32'd0);
      chk("rst_done",   32'(o_done),   32'd0);
      chk("rst_count",  32'(o_count),  32'd0);
      chk("rst_ovf",    32'(o_ovf),    32'd0);
      chk("rst_chksum", 32'(o_chksum), 32'd0);
      chk("rst_wait",   32'(dl.O_DL_WAIT), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Session A: out-of-window strobes, then a single byte at offset 1FF
      start_session();
      chk("armed_cnf_en", 32'(o_cnf_en), 32'd1);
      strobe(BASE - 16'd1, 8'h77);
      strobe(BASE + 16'd512, 8'h88);
      repeat (4) tick();
      chk("oow_count", 32'(o_count), 32'd0);
      expect_wr(9'h1FF, 8'h3C);
      strobe(BASE + 16'h01FF, 8'h3C);
      tick();
      chk("single_a",     32'(o_cnf_a), 32'h0000_00FF);
      chk("single_d",     32'(o_cnf_d), 32'h0000_003C);
      chk("single_setup", 32'(o_we3),   32'd0);
      tick();
      chk("single_we3",   32'(o_we3),   32'd1);
      chk("single_we2",   32'(o_we2),   32'd0);
      tick();
      chk("single_we3_off", 32'(o_we3),   32'd0);
      chk("single_count",   32'(o_count), 32'd1);
      dl.I_DL_ACTIVE = 1'b0;
      wait_done(10, n);
      chk("done_latency", 32'(n), 32'd1);
      chk("done_cnf_en",  32'(o_cnf_en), 32'd0);
      chk("done_cnf_d",   32'(o_cnf_d),  32'd0);
      chk("single_chksum", 32'(o_chksum), CK_EN ? 32'h0000_003C : 32'd0);
      tick();
      chk("done_one_cycle", 32'(o_done), 32'd0);

      // Session B: full sequential load, plus one rewrite to show COUNT saturates
      start_session();
      chk("clear_count", 32'(o_count), 32'd0);
      we2_n = 0;
      we3_n = 0;
      exp_sum = '0;
      for (int o = 0; o < 512; o++) begin
         d = 8'(o) ^ 8'hA5;
         expect_wr(9'(o), d);
         exp_sum = exp_sum + {8'h00, d};
         strobe(BASE + 16'(o), d);
         repeat (3) tick();
      end
      chk("seq_count", 32'(o_count), 32'd512);
      expect_wr(9'h000, 8'h11);
      exp_sum = exp_sum + 16'h0011;
      strobe(BASE, 8'h11);
      repeat (3) tick();
      chk("sat_count", 32'(o_count), 32'd512);
      dl.I_DL_ACTIVE = 1'b0;
      wait_done(10, n);
      chk("seq_we2_n",  32'(we2_n), 32'd257);
      chk("seq_we3_n",  32'(we3_n), 32'd256);
      chk("seq_ovf",    32'(o_ovf), 32'd0);
      chk("seq_chksum", 32'(o_chksum), CK_EN ? 32'(exp_sum) : 32'd0);
      tick();
      chk("seq_done_n", 32'(done_n), 32'd1);

      // Session C: 6-byte burst from a source that honours WAIT
      start_session();
      for (int i = 0; i < 6; i++) begin
         n = 0;
         while (dl.O_DL_WAIT === 1'b1 && n < 50) begin
            tick();
            n++;
         end
         expect_wr(9'h040 + 9'(i), 8'h50 + 8'(i));
         strobe(BASE + 16'h0040 + 16'(i), 8'h50 + 8'(i));
      end
      repeat (25) tick();
      chk("honour_wait_seen", 32'(wait_seen), 32'd1);
      chk("honour_count",     32'(o_count),   32'd6);
      chk("honour_ovf",       32'(o_ovf),     32'd0);
      chk("honour_drained",   32'(exp_q.size()), 32'd0);
      dl.I_DL_ACTIVE = 1'b0;
      wait_done(10, n);
      tick();

      // Session D: lead byte then 6 strobes ignoring WAIT; the sixth is dropped
      start_session();
      expect_wr(9'h100, 8'hE0);
      strobe(BASE + 16'h0100, 8'hE0);
      for (int i = 1; i <= 6; i++) begin
         if (i < 6) expect_wr(9'h100 + 9'(i), 8'hE0 + 8'(i));
         strobe(BASE + 16'h0100 + 16'(i), 8'hE0 + 8'(i));
      end
      repeat (25) tick();
      chk("ignore_wait_seen", 32'(wait_seen), 32'd1);
      chk("ignore_ovf",       32'(o_ovf),     32'd1);
      chk("ignore_count",     32'(o_count),   32'd6);
      dl.I_DL_ACTIVE = 1'b0;
      wait_done(10, n);
      chk("ovf_sticky", 32'(o_ovf), 32'd1);
      tick();

      // Session E: ACTIVE falls with 3 bytes buffered; a brief re-rise must not re-clear
      start_session();
      chk("ovf_cleared", 32'(o_ovf), 32'd0);
      for (int i = 0; i < 4; i++) begin
         expect_wr(9'h010 + 9'(i), 8'h21 + 8'(i));
         strobe(BASE + 16'h0010 + 16'(i), 8'h21 + 8'(i));
      end
      dl.I_DL_ACTIVE = 1'b0;
      tick();
      dl.I_DL_ACTIVE = 1'b1;
      tick();
      dl.I_DL_ACTIVE = 1'b0;
      wait_done(60, n);
      chk("early_done_latency", 32'(n),        32'd8);
      chk("early_count",        32'(o_count),  32'd4);
      chk("early_cnf_en",       32'(o_cnf_en), 32'd0);
      tick();

      // Session F: reset asserted in the middle of a WRITE cycle
      start_session();
      expect_wr(9'h080, 8'h91);
      for (int i = 0; i < 4; i++) strobe(BASE + 16'h0080 + 16'(i), 8'h91 + 8'(i));
      tick();
      tick();
      chk("rstw_we2_pre",   32'(o_we2),   32'd1);
      chk("rstw_count_pre", 32'(o_count), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      chk("rstw_we2",    32'(o_we2),    32'd0);
      chk("rstw_cnf_en", 32'(o_cnf_en), 32'd0);
      chk("rstw_count",  32'(o_count),  32'd0);
      chk("rstw_ovf",    32'(o_ovf),    32'd0);
      chk("rstw_chksum", 32'(o_chksum), 32'd0);
      dl.I_DL_ACTIVE = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      start_session();
      repeat (6) tick();
      chk("fresh_count", 32'(o_count), 32'd0);
      chk("fresh_wait",  32'(dl.O_DL_WAIT), 32'd0);
      expect_wr(9'h0AA, 8'h5A);
      strobe(BASE + 16'h00AA, 8'h5A);
      repeat (3) tick();
      dl.I_DL_ACTIVE = 1'b0;
      wait_done(10, n);
      chk("fresh_done_count", 32'(o_count),  32'd1);
      chk("fresh_chksum",     32'(o_chksum), CK_EN ? 32'h0000_005A : 32'd0);
      tick();
      chk("all_writes_seen", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/dkong_pal_loader.md
# dkong_pal_loader

Writer side of the colour-palette configuration port. It takes the 512 palette PROM bytes from the download stream and buffers them in a 4-entry FIFO. It then sequences them into the two palette RAM banks (2E, then 2F) through the CNF address/data/enable and WE2/WE3 strobes. It sits between the download interface and the colour palette block, and owns CNF_EN for the whole load window.

## Interface
- BASE_ADDR, 16'h0000: first download address of the palette window (512 bytes, BASE_ADDR..BASE_ADDR+511).
- FIFO_DEPTH, 4: buffer entries. Fixed at 4; other values are unsupported.
- CLK_6M  in  1  clock; all logic on the rising edge.
- W_1EF_RST  in  1  reset, asynchronous, active-low.
- I_DL_ACTIVE  in  1  download session active (level).
- I_DL_WR  in  1  byte strobe, one cycle per byte.
- I_DL_ADDR  in  16  download byte address.
- I_DL_DATA  in  8  download byte.
- O_DL_WAIT  out  1  backpressure; source must hold further strobes while high.
- O_CNF_EN  out  1  palette port owned by loader.
- O_CNF_A  out  8  palette RAM address.
- O_CNF_D  out  8  palette RAM write data.
- O_WE2  out  1  write strobe, bank 2E.
- O_WE3  out  1  write strobe, bank 2F.
- O_DONE  out  1  one-cycle pulse when the load completes.
- O_COUNT  out  10  bytes written this session (0..512).
- O_OVF  out  1  sticky: a byte was dropped on a full FIFO.
- O_CHKSUM  out  16  running additive checksum (see Configuration).

## Operation
- Window decode: a strobe is accepted only when I_DL_ACTIVE=1 and BASE_ADDR ≤ I_DL_ADDR ≤ BASE_ADDR+511. Offset = I_DL_ADDR-BASE_ADDR (9 bits).
  - Offset bit 8 = 0 selects 2E (WE2); bit 8 = 1 selects 2F (WE3).
  - Offset bits 7:0 form CNF_A.
  - Accepted strobes push {offset[8:0], data[7:0]} into the FIFO.
- FSM states: IDLE, ARMED, SETUP, WRITE, DONE.
  - IDLE: waits for a rising edge of I_DL_ACTIVE. On that edge it clears O_COUNT, O_OVF and the checksum, then goes to ARMED.
  - ARMED:
    - FIFO non-empty: pop one entry, load the CNF_A/CNF_D/bank registers, go to SETUP.
    - FIFO empty and I_DL_ACTIVE=0: go to DONE.
  - SETUP: holds A/D with no WE for one cycle, then goes to WRITE.
  - WRITE: drives WE2 or WE3 high for exactly one cycle with A/D held. Increments O_COUNT, saturating at 512. Then goes to ARMED.
  - DONE: O_DONE=1 for one cycle, then IDLE.
- O_CNF_EN = 1 in ARMED, SETUP and WRITE; 0 in IDLE and DONE.
- O_CNF_D = 8'h00 whenever O_CNF_EN=0.
- FIFO rules:
  - Push and pop in the same cycle leave the count unchanged.
  - A push with count=4 and no pop drops the byte and sets O_OVF.
  - O_DL_WAIT is registered, = (count ≥ 3).
- Bytes are written in arrival order. A repeated offset rewrites the same location, and O_COUNT counts every write.
- I_DL_ACTIVE falling while the FIFO is non-empty: all buffered bytes still drain before DONE.
- I_DL_ACTIVE rising again before DONE: ignored. No re-clear occurs.
- Reset mid-load: asynchronously forces state IDLE, flushes the FIFO, and drives all outputs to 0 immediately.

## Timing
- Reset values: every output is 0, including O_CNF_A, O_CNF_D and O_CHKSUM.
- Strobe sampled at edge k: entry is in the FIFO after edge k. If the FSM is ARMED with an empty FIFO, SETUP is entered at edge k+1, so A/D are valid from k+1 and WE is high from edge k+2 to edge k+3.
- Throughput: one byte per 3 cycles (ARMED, SETUP, WRITE).
- O_DL_WAIT rises the cycle after the count reaches 3.
- O_DONE occurs one cycle after ARMED sees an empty FIFO with I_DL_ACTIVE low.
- O_CNF_EN drops in the same cycle as O_DONE.
- WE2 and WE3 are never high together. No WE is issued outside WRITE.

## Configuration
- DKONG_PAL_CHKSUM_EN:
  - Defined: O_CHKSUM accumulates a 16-bit wrapping sum of every O_CNF_D value written, updated at the end of WRITE and cleared on session start.
  - Undefined: the accumulator is not built and O_CHKSUM is tied to 16'h0000.

## Structure
- Package dkong_pal_pkg:
  - FSM state enum (IDLE, ARMED, SETUP, WRITE, DONE).
  - PAL_BYTES=512, FIFO_DEPTH=4, WAIT_LEVEL=3.
  - FIFO entry width 17.
- Sub-module dkong_pal_fifo: 4×17 register FIFO with push, pop, count[2:0], full and empty outputs.

## Test plan
- Sequential load: strobes every 4 cycles at BASE_ADDR+0..511 with data = offset[7:0]^8'hA5. Expect:
  - 256 WE2 and 256 WE3 pulses, each with CNF_A = offset[7:0] and CNF_D = expected data.
  - O_COUNT=512, one O_DONE pulse.
  - O_CHKSUM equal to the software sum when DKONG_PAL_CHKSUM_EN is defined.
- Burst: 6 back-to-back strobes.
  - O_DL_WAIT rises.
  - If the source honours WAIT: all 6 bytes are written in order and O_OVF=0.
  - If the source ignores WAIT: at least one byte is dropped and O_OVF=1.
- Out-of-window traffic: strobes at BASE_ADDR-1 and BASE_ADDR+512. Expect no FIFO push, no WE pulse, O_COUNT=0.
- Early session end: I_DL_ACTIVE falls with 3 entries buffered. Expect 3 more WRITE cycles, then O_DONE, then O_CNF_EN=0.
- Reset asserted during a WRITE cycle:
  - WE, CNF_EN, COUNT and OVF go to 0 asynchronously.
  - After release, a fresh session starts from an empty FIFO.
- Single byte at offset 9'h1FF, data 8'h3C, into an idle ARMED FSM:
  - CNF_A=8'hFF and CNF_D=8'h3C one cycle after the strobe edge.
  - WE3 high for exactly one cycle starting two cycles after the strobe edge; WE2 stays 0.
